// File: rtl/noc_conc_pkg.sv
// Shared types and width helpers for the NoC packet concentrator.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package noc_conc_pkg;

    // Outbound link state: waiting for a packet, or streaming one out
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } conc_state_t;

    // $clog2 that never returns 0, so counters and pointers keep at least one bit
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a byte-within-packet counter
    function automatic int cnt_w(input int pkt_bytes);
        return clog2_min1(pkt_bytes);
    endfunction

    // Width of a channel index / round-robin pointer
    function automatic int ptr_w(input int num_ch);
        return clog2_min1(num_ch);
    endfunction

endpackage

// File: rtl/noc_pkt_fifo.sv
// Per-channel store-and-forward packet FIFO with inbound protocol checking.
// Latency: a packet is readable the cycle after its last inbound byte.
// Backpressure: in_free drops when every slot is held or being filled; its slot frees on rd_done.
module noc_pkt_fifo
    import noc_conc_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int PKT_BYTES = 4,
    parameter int DEPTH     = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_put,
    input  logic [WIDTH-1:0] wr_payload,
    input  logic             rd_pop,
    input  logic             rd_done,
    output logic             pkt_avail,
    output logic [WIDTH-1:0] rd_byte,
    output logic             in_free,
    output logic             proto_err
);

    localparam int CNT_W  = cnt_w(PKT_BYTES);
    localparam int SLOT_W = clog2_min1(DEPTH);
    localparam int NB     = DEPTH * PKT_BYTES;
    localparam int ADDR_W = clog2_min1(NB);
    localparam int NUM_W  = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(PKT_BYTES - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(DEPTH - 1);

    logic [WIDTH-1:0]  mem [NB];
    logic [CNT_W-1:0]  wr_cnt, wr_cnt_nxt, rd_cnt;
    logic [SLOT_W-1:0] wr_slot, rd_slot;
    // n_ready: complete packets not yet started; n_held: complete packets still occupying a slot
    logic [NUM_W-1:0]  n_ready, n_held, held_nxt;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic              accept, gap, overrun, wr_last, free_nxt;

    // Classify the inbound byte and compute next occupancy / free state
    always_comb begin
        accept   = wr_put && ((wr_cnt != '0) || in_free);
        overrun  = wr_put && (wr_cnt == '0) && !in_free;
        gap      = !wr_put && (wr_cnt != '0);
        wr_last  = accept && (wr_cnt == CNT_LAST);
        wr_cnt_nxt = wr_cnt;
        if (gap || wr_last)
            wr_cnt_nxt = '0;
        else if (accept)
            wr_cnt_nxt = wr_cnt + CNT_W'(1);
        held_nxt = n_held + NUM_W'(wr_last) - NUM_W'(rd_done);
        free_nxt = (int'(held_nxt) + int'(wr_cnt_nxt != '0)) < DEPTH;
        wr_addr  = ADDR_W'(int'(wr_slot) * PKT_BYTES + int'(wr_cnt));
        rd_addr  = ADDR_W'(int'(rd_slot) * PKT_BYTES + int'(rd_cnt));
    end

    assign pkt_avail = (n_ready != '0);
    assign rd_byte   = mem[rd_addr];

    // Byte storage; a discarded partial packet is simply overwritten later
    always_ff @(posedge clock) begin
        if (accept)
            mem[wr_addr] <= wr_payload;
    end

    // Write/read pointers, slot accounting and sticky error flag
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_cnt    <= '0;
            wr_slot   <= '0;
            rd_cnt    <= '0;
            rd_slot   <= '0;
            n_ready   <= '0;
            n_held    <= '0;
            in_free   <= 1'b1;
            proto_err <= 1'b0;
        end else begin
            wr_cnt  <= wr_cnt_nxt;
            if (wr_last)
                wr_slot <= (wr_slot == SLOT_LAST) ? '0 : wr_slot + SLOT_W'(1);
            if (rd_pop) begin
                if (rd_cnt == CNT_LAST) begin
                    rd_cnt  <= '0;
                    rd_slot <= (rd_slot == SLOT_LAST) ? '0 : rd_slot + SLOT_W'(1);
                end else begin
                    rd_cnt <= rd_cnt + CNT_W'(1);
                end
            end
            n_ready <= n_ready + NUM_W'(wr_last) - NUM_W'(rd_pop && (rd_cnt == '0));
            n_held  <= held_nxt;
            in_free <= free_nxt;
            if (gap || overrun)
                proto_err <= 1'b1;
        end
    end

endmodule

// File: rtl/noc_concentrator.sv
// Merges NUM_CH store-and-forward inbound links onto one outbound link, round-robin per packet.
// Latency: last inbound byte at t -> first outbound byte at t+2 on an idle link.
// Backpressure: out_free gates only packet starts; per-channel in_free gates inbound starts.
module noc_concentrator
    import noc_conc_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int WIDTH     = 8,
    parameter int PKT_BYTES = 4,
    parameter int DEPTH     = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_CH-1:0]             in_put,
    input  logic [NUM_CH-1:0][WIDTH-1:0]  in_payload,
    output logic [NUM_CH-1:0]             in_free,
    output logic                          out_put,
    output logic [WIDTH-1:0]              out_payload,
    input  logic                          out_free,
    output logic [NUM_CH-1:0]             proto_err
);

    localparam int CNT_W = cnt_w(PKT_BYTES);
    localparam int PTR_W = ptr_w(NUM_CH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PKT_BYTES - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_CH - 1);

    conc_state_t                   state;
    logic [PTR_W-1:0]              grant, rr_ptr, pick, idx_p;
    logic [CNT_W-1:0]              out_idx;
    logic                          pick_vld, cont, done, new_pkt;
    logic [NUM_CH-1:0]             pkt_avail, pop, rd_done;
    logic [NUM_CH-1:0][WIDTH-1:0]  fifo_byte;
    int                            idx;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        noc_pkt_fifo #(
            .WIDTH     (WIDTH),
            .PKT_BYTES (PKT_BYTES),
            .DEPTH     (DEPTH)
        ) u_fifo (
            .clock      (clock),
            .reset      (reset),
            .wr_put     (in_put[i]),
            .wr_payload (in_payload[i]),
            .rd_pop     (pop[i]),
            .rd_done    (rd_done[i]),
            .pkt_avail  (pkt_avail[i]),
            .rd_byte    (fifo_byte[i]),
            .in_free    (in_free[i]),
            .proto_err  (proto_err[i])
        );
    end

    // Round-robin pick: first channel with a complete packet, scanning up from rr_ptr
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        idx      = 0;
        idx_p    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx   = (int'(rr_ptr) + k) % NUM_CH;
            idx_p = PTR_W'(idx);
            if (!pick_vld && pkt_avail[idx_p]) begin
                pick_vld = 1'b1;
                pick     = idx_p;
            end
        end
    end

    // Per-cycle control: continue the current packet, or start a new one at a boundary
    always_comb begin
        cont    = (state == SEND) && (out_idx != CNT_LAST);
        done    = (state == SEND) && (out_idx == CNT_LAST);
        new_pkt = ((state == IDLE) || done) && out_free && pick_vld;
        pop     = '0;
        rd_done = '0;
        if (cont)
            pop[grant] = 1'b1;
        if (new_pkt)
            pop[pick] = 1'b1;
        if (done)
            rd_done[grant] = 1'b1;
    end

    // Outbound FSM with registered byte/valid; rr_ptr moves past the winner as soon as it is
    // granted, which is equivalent to moving it on the last byte since no scan happens in between
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= '0;
            rr_ptr      <= '0;
            out_idx     <= '0;
            out_put     <= 1'b0;
            out_payload <= '0;
        end else if (cont) begin
            out_payload <= fifo_byte[grant];
            out_idx     <= out_idx + CNT_W'(1);
            out_put     <= 1'b1;
        end else if (new_pkt) begin
            state       <= SEND;
            grant       <= pick;
            rr_ptr      <= (pick == PTR_LAST) ? '0 : pick + PTR_W'(1);
            out_payload <= fifo_byte[pick];
            out_idx     <= '0;
            out_put     <= 1'b1;
        end else begin
            state   <= IDLE;
            out_idx <= '0;
            out_put <= 1'b0;
        end
    end

endmodule

// File: tb/tb_noc_concentrator.sv
// Directed-sequence bench with random payloads, checked against a packet-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_noc_concentrator;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [3:0]       in_put = '0;
    logic [3:0][7:0]  in_payload = '0;
    logic [3:0]       in_free;
    logic             out_put;
    logic [7:0]       out_payload;
    logic             out_free = 1'b1;
    logic [3:0]       proto_err;

    noc_concentrator #(
        .NUM_CH(4), .WIDTH(8), .PKT_BYTES(4), .DEPTH(2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in_put      (in_put),
        .in_payload  (in_payload),
        .in_free     (in_free),
        .out_put     (out_put),
        .out_payload (out_payload),
        .out_free    (out_free),
        .proto_err   (proto_err)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [7:0] obs_q[$];
    int         obs_cyc[$];
    int         obs_base;
    logic [7:0] exp_q[$];
    logic [31:0] pend[4][$];
    int          model_rr;
    logic [3:0]  free_and;

    always @(posedge clock) cyc <= cyc + 1;

    // Capture every outbound byte with its cycle stamp, away from the clock edge
    always @(negedge clock) begin
        if (out_put) begin
            obs_q.push_back(out_payload);
            obs_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step(input logic [3:0] put, input logic [3:0][7:0] pay);
        @(posedge clock);
        #1;
        in_put     = put;
        in_payload = pay;
        free_and   = free_and & in_free;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'b0000, '0);
    endtask

    // Drive one packet on every channel in mask at once; byte 0 is the MSB of each word
    task automatic send_multi(input logic [3:0] mask, input logic [3:0][31:0] pkts);
        logic [3:0][7:0] pay;
        for (int b = 0; b < 4; b++) begin
            for (int c = 0; c < 4; c++) pay[c] = pkts[c][31-8*b -: 8];
            step(mask, pay);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        model_rr = 0;
        for (int c = 0; c < 4; c++) pend[c].delete();
        exp_q.delete();
        idle(1);
        obs_base = obs_q.size();
        free_and = 4'hF;
    endtask

    // Packet-level reference: whole packets leave one at a time, the next chosen
    // round-robin among channels that hold one, starting after the previous winner
    task automatic model_drain();
        bit got;
        int ch;
        logic [31:0] p;
        do begin
            got = 1'b0;
            for (int k = 0; k < 4; k++) begin
                ch = (model_rr + k) % 4;
                if (!got && pend[ch].size() > 0) begin
                    p = pend[ch].pop_front();
                    for (int b = 0; b < 4; b++) exp_q.push_back(p[31-8*b -: 8]);
                    model_rr = (ch + 1) % 4;
                    got = 1'b1;
                end
            end
        end while (got);
    endtask

    task automatic cmp_stream(input string tag);
        int n_obs;
        n_obs = obs_q.size() - obs_base;
        chk({tag, "_len"}, 64'(n_obs), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < n_obs; i++)
            chk($sformatf("%s_b%0d", tag, i), 64'(obs_q[obs_base+i]), 64'(exp_q[i]));
    endtask

    task automatic chk_contig(input string tag, input int n);
        int gaps = 0;
        for (int i = 1; i < n && obs_base + i < obs_cyc.size(); i++)
            if (obs_cyc[obs_base+i] != obs_cyc[obs_base] + i) gaps++;
        chk(tag, 64'(gaps), 64'd0);
    endtask

    initial begin
        logic [3:0][31:0] pk, pk2;
        int t, r;

        // Reset state
        free_and = 4'hF;
        do_reset();
        chk("rst_in_free", 64'(in_free), 64'hF);
        chk("rst_out_put", 64'(out_put), 64'd0);
        chk("rst_out_payload", 64'(out_payload), 64'd0);
        chk("rst_proto_err", 64'(proto_err), 64'd0);

        // Single packet on ch2, first byte two cycles after last inbound byte
        pk = '0;
        pk[2] = 32'hA1B2C3D4;
        pend[2].push_back(pk[2]);
        send_multi(4'b0100, pk);
        t = cyc;
        idle(12);
        model_drain();
        cmp_stream("s1");
        if (obs_cyc.size() > obs_base)
            chk("s1_first_cycle", 64'(obs_cyc[obs_base]), 64'(t + 2));
        chk_contig("s1_contig", 4);
        chk("s1_in_free2", 64'(free_and[2]), 64'd1);

        // All channels, two packets each: 32 back-to-back bytes, rr wraps to ch0
        do_reset();
        for (int c = 0; c < 4; c++) begin
            pk[c]  = $urandom();
            pk2[c] = $urandom();
            pend[c].push_back(pk[c]);
            pend[c].push_back(pk2[c]);
        end
        send_multi(4'b1111, pk);
        send_multi(4'b1111, pk2);
        idle(45);
        model_drain();
        cmp_stream("s2");
        chk_contig("s2_contig", 32);

        // ch1 fills both slots with out_free low; third start is rejected
        do_reset();
        out_free = 1'b0;
        pk = '0;
        pk2 = '0;
        pk[1]  = $urandom();
        pk2[1] = $urandom();
        pend[1].push_back(pk[1]);
        pend[1].push_back(pk2[1]);
        send_multi(4'b0010, pk);
        step(4'b0010, {8'h0, 8'h0, pk2[1][31:24], 8'h0});
        step(4'b0010, {8'h0, 8'h0, pk2[1][23:16], 8'h0});
        chk("s3_in_free1_low", 64'(in_free[1]), 64'd0);
        step(4'b0010, {8'h0, 8'h0, pk2[1][15:8], 8'h0});
        step(4'b0010, {8'h0, 8'h0, pk2[1][7:0], 8'h0});
        step(4'b0010, {8'h0, 8'h0, 8'h5A, 8'h0});
        idle(2);
        chk("s3_proto_err", 64'(proto_err), 64'h2);
        chk("s3_in_free1_full", 64'(in_free[1]), 64'd0);
        chk("s3_nothing_yet", 64'(obs_q.size() - obs_base), 64'd0);
        out_free = 1'b1;
        idle(20);
        model_drain();
        cmp_stream("s3");
        chk("s3_in_free1_back", 64'(in_free[1]), 64'd1);

        // ch3 gap after two bytes: flagged, discarded, slot stays free
        do_reset();
        step(4'b1000, {8'h11, 8'h0, 8'h0, 8'h0});
        step(4'b1000, {8'h22, 8'h0, 8'h0, 8'h0});
        idle(10);
        chk("s4_proto_err", 64'(proto_err), 64'h8);
        chk("s4_in_free3", 64'(free_and[3]), 64'd1);
        chk("s4_no_output", 64'(obs_q.size() - obs_base), 64'd0);
        pk = '0;
        pk[3] = $urandom();
        pend[3].push_back(pk[3]);
        send_multi(4'b1000, pk);
        idle(10);
        model_drain();
        cmp_stream("s4");

        // out_free drops mid-packet: packet completes, next waits for out_free
        do_reset();
        pk = '0;
        pk[0] = $urandom();
        pk[1] = $urandom();
        pend[0].push_back(pk[0]);
        pend[1].push_back(pk[1]);
        send_multi(4'b0011, pk);
        t = cyc;
        idle(3);
        out_free = 1'b0;
        idle(8);
        chk("s5_held_count", 64'(obs_q.size() - obs_base), 64'd4);
        step(4'b0000, '0);
        out_free = 1'b1;
        r = cyc;
        idle(12);
        model_drain();
        cmp_stream("s5");
        chk_contig("s5_first_contig", 4);
        if (obs_cyc.size() > obs_base + 4) begin
            chk("s5_first_cycle", 64'(obs_cyc[obs_base]), 64'(t + 2));
            chk("s5_resume_window", 64'((obs_cyc[obs_base+4] >= r + 1) && (obs_cyc[obs_base+4] <= r + 2)), 64'd1);
        end else begin
            chk("s5_resume_seen", 64'd0, 64'd1);
        end

        // Reset while byte 2 is on the outbound link
        do_reset();
        pk[0] = $urandom();
        pk[1] = $urandom();
        send_multi(4'b0011, pk);
        t = cyc;
        idle(4);
        reset = 1'b1;
        step(4'b0000, '0);
        chk("s6_out_put", 64'(out_put), 64'd0);
        chk("s6_in_free", 64'(in_free), 64'hF);
        chk("s6_proto_err", 64'(proto_err), 64'd0);
        reset = 1'b0;
        idle(20);
        exp_q.delete();
        for (int b = 0; b < 3; b++) exp_q.push_back(pk[0][31-8*b -: 8]);
        cmp_stream("s6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
